// File: rtl/sba_branch_resolve_pkg.sv
// Shared widths and the BPU update record used by the SBA branch-resolve stage.
// The update record is {pc, take, dest}; its packed layout is the FIFO entry format.
package sba_branch_resolve_pkg;

    localparam int SINGLE_WORD_W    = 32;
    localparam int GPR_NUM_W        = 5;
    localparam int REPAIR_ACTION_W  = 4;
    localparam int ALL_CHECKPOINT_W = 8;
    localparam int NEED_REPAIR      = REPAIR_ACTION_W - 1;
    localparam int UPD_DEPTH_DEF    = 4;

    typedef struct packed {
        logic [SINGLE_WORD_W-1:0] pc;
        logic                     take;
        logic [SINGLE_WORD_W-1:0] dest;
    } bpu_upd_t;

    localparam int UPD_ENTRY_W = $bits(bpu_upd_t);

endpackage

// File: rtl/sba_branch_resolve_sync_fifo.sv
// Small synchronous FIFO for BPU training updates; head data is read combinationally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sba_branch_resolve_sync_fifo
    import sba_branch_resolve_pkg::*;
#(
    parameter int WIDTH = UPD_ENTRY_W,
    parameter int DEPTH = UPD_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: the array is reset so the head outputs read as zero while empty after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sba_branch_resolve.sv
// SBA stage: registers EXE_up's resolved branch, raises a one-shot mispredict flush,
// forwards the ALU result and queues every resolved branch for BPU training.
module sba_branch_resolve
    import sba_branch_resolve_pkg::*;
#(
    parameter int UPD_DEPTH = UPD_DEPTH_DEF,
    parameter int REPAIR_W  = REPAIR_ACTION_W,
    parameter int CKPT_W    = ALL_CHECKPOINT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                EXE_up_valid_w_i,
    input  logic [31:0]         EXE_up_VAddr_i,
    input  logic [4:0]          EXE_up_writeNum_i,
    input  logic [31:0]         EXE_up_aluRes_i,
    input  logic                EXE_up_isBranch_i,
    input  logic                EXE_up_branchRisk_i,
    input  logic                EXE_up_corrTake_i,
    input  logic [31:0]         EXE_up_corrDest_i,
    input  logic [REPAIR_W-1:0] EXE_up_repairAction_i,
    input  logic [CKPT_W-1:0]   EXE_up_checkPoint_i,
    input  logic                NEXT_allowin_w_i,
    input  logic                CP0_excOccur_w_i,
    output logic                SBA_allowin_w_o,
    output logic                SBA_valid_w_o,
    output logic [4:0]          SBA_writeNum_o,
    output logic [31:0]         SBA_aluRes_o,
    output logic                SBA_flush_w_o,
    output logic [31:0]         SBA_redirectPC_o,
    output logic [REPAIR_W-1:0] SBA_repairAction_o,
    output logic [CKPT_W-1:0]   SBA_checkPoint_o,
    output logic                BPU_updValid_o,
    input  logic                BPU_updReady_i,
    output logic [31:0]         BPU_updPC_o,
    output logic                BPU_updTake_o,
    output logic [31:0]         BPU_updDest_o,
    output logic [31:0]         SBA_mispredCnt_o
);

    logic                has_data;
    logic                flush_sent;
    logic [31:0]         vaddr_r;
    logic [4:0]          write_num_r;
    logic [31:0]         alu_res_r;
    logic                is_branch_r;
    logic                branch_risk_r;
    logic                corr_take_r;
    logic [31:0]         corr_dest_r;
    logic [REPAIR_W-1:0] repair_action_r;
    logic [CKPT_W-1:0]   check_point_r;
    logic [31:0]         mispred_cnt;

    logic     fire_in;
    logic     fire_out;
    logic     fifo_block;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;
    logic     fifo_pop;
    bpu_upd_t upd_in;
    bpu_upd_t upd_head;

    assign fifo_pop   = BPU_updValid_o & BPU_updReady_i;
    assign fifo_block = is_branch_r & fifo_full & ~fifo_pop;
    assign fire_out   = has_data & NEXT_allowin_w_i & ~fifo_block;
    // Gated by rst so the stage advertises nothing while reset is held.
    assign SBA_allowin_w_o = rst & (~has_data | fire_out);
    assign fire_in         = EXE_up_valid_w_i & SBA_allowin_w_o;
    assign fifo_push       = fire_out & is_branch_r & ~CP0_excOccur_w_i;

    assign SBA_valid_w_o      = has_data & ~fifo_block & ~CP0_excOccur_w_i;
    assign SBA_flush_w_o      = has_data & branch_risk_r & ~flush_sent & ~CP0_excOccur_w_i;
    assign SBA_writeNum_o     = write_num_r;
    assign SBA_aluRes_o       = alu_res_r;
    assign SBA_redirectPC_o   = corr_dest_r;
    assign SBA_repairAction_o = repair_action_r;
    assign SBA_checkPoint_o   = check_point_r;
    assign SBA_mispredCnt_o   = mispred_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vaddr_r         <= '0;
            write_num_r     <= '0;
            alu_res_r       <= '0;
            is_branch_r     <= 1'b0;
            branch_risk_r   <= 1'b0;
            corr_take_r     <= 1'b0;
            corr_dest_r     <= '0;
            repair_action_r <= '0;
            check_point_r   <= '0;
        end else if (fire_in) begin
            vaddr_r         <= EXE_up_VAddr_i;
            write_num_r     <= EXE_up_writeNum_i;
            alu_res_r       <= EXE_up_aluRes_i;
            is_branch_r     <= EXE_up_isBranch_i;
            branch_risk_r   <= EXE_up_branchRisk_i;
            corr_take_r     <= EXE_up_corrTake_i;
            corr_dest_r     <= EXE_up_corrDest_i;
            repair_action_r <= EXE_up_repairAction_i;
            check_point_r   <= EXE_up_checkPoint_i;
        end
    end

    // A new instruction re-arms the flush even when it arrives in the flush cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            has_data   <= 1'b0;
            flush_sent <= 1'b0;
        end else if (CP0_excOccur_w_i) begin
            has_data   <= 1'b0;
            flush_sent <= 1'b0;
        end else begin
            has_data <= fire_in | (has_data & ~fire_out);
            if (fire_in)
                flush_sent <= 1'b0;
            else if (SBA_flush_w_o)
                flush_sent <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mispred_cnt <= '0;
        else if (SBA_flush_w_o && mispred_cnt != '1)
            mispred_cnt <= mispred_cnt + 32'd1;
    end

    assign upd_in = '{pc: vaddr_r, take: corr_take_r, dest: corr_dest_r};

    sba_branch_resolve_sync_fifo #(
        .WIDTH (UPD_ENTRY_W),
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (upd_in),
        .dout  (upd_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign BPU_updValid_o = ~fifo_empty;
    assign BPU_updPC_o    = upd_head.pc;
    assign BPU_updTake_o  = upd_head.take;
    assign BPU_updDest_o  = upd_head.dest;

endmodule

// File: tb/tb_sba_branch_resolve.sv
// Directed bench for sba_branch_resolve: hand-computed expectations for hand-off,
// flush, FIFO full/back-pressure, exception kill and mid-stream reset.
module tb_sba_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXE_up_valid_w_i;
    logic [31:0] EXE_up_VAddr_i;
    logic [4:0]  EXE_up_writeNum_i;
    logic [31:0] EXE_up_aluRes_i;
    logic        EXE_up_isBranch_i;
    logic        EXE_up_branchRisk_i;
    logic        EXE_up_corrTake_i;
    logic [31:0] EXE_up_corrDest_i;
    logic [3:0]  EXE_up_repairAction_i;
    logic [7:0]  EXE_up_checkPoint_i;
    logic        NEXT_allowin_w_i;
    logic        CP0_excOccur_w_i;
    logic        SBA_allowin_w_o;
    logic        SBA_valid_w_o;
    logic [4:0]  SBA_writeNum_o;
    logic [31:0] SBA_aluRes_o;
    logic        SBA_flush_w_o;
    logic [31:0] SBA_redirectPC_o;
    logic [3:0]  SBA_repairAction_o;
    logic [7:0]  SBA_checkPoint_o;
    logic        BPU_updValid_o;
    logic        BPU_updReady_i;
    logic [31:0] BPU_updPC_o;
    logic        BPU_updTake_o;
    logic [31:0] BPU_updDest_o;
    logic [31:0] SBA_mispredCnt_o;

    int n_vec = 0;
    int n_bad = 0;

    sba_branch_resolve dut (
        .clk                   (clk),
        .rst                   (rst),
        .EXE_up_valid_w_i      (EXE_up_valid_w_i),
        .EXE_up_VAddr_i        (EXE_up_VAddr_i),
        .EXE_up_writeNum_i     (EXE_up_writeNum_i),
        .EXE_up_aluRes_i       (EXE_up_aluRes_i),
        .EXE_up_isBranch_i     (EXE_up_isBranch_i),
        .EXE_up_branchRisk_i   (EXE_up_branchRisk_i),
        .EXE_up_corrTake_i     (EXE_up_corrTake_i),
        .EXE_up_corrDest_i     (EXE_up_corrDest_i),
        .EXE_up_repairAction_i (EXE_up_repairAction_i),
        .EXE_up_checkPoint_i   (EXE_up_checkPoint_i),
        .NEXT_allowin_w_i      (NEXT_allowin_w_i),
        .CP0_excOccur_w_i      (CP0_excOccur_w_i),
        .SBA_allowin_w_o       (SBA_allowin_w_o),
        .SBA_valid_w_o         (SBA_valid_w_o),
        .SBA_writeNum_o        (SBA_writeNum_o),
        .SBA_aluRes_o          (SBA_aluRes_o),
        .SBA_flush_w_o         (SBA_flush_w_o),
        .SBA_redirectPC_o      (SBA_redirectPC_o),
        .SBA_repairAction_o    (SBA_repairAction_o),
        .SBA_checkPoint_o      (SBA_checkPoint_o),
        .BPU_updValid_o        (BPU_updValid_o),
        .BPU_updReady_i        (BPU_updReady_i),
        .BPU_updPC_o           (BPU_updPC_o),
        .BPU_updTake_o         (BPU_updTake_o),
        .BPU_updDest_o         (BPU_updDest_o),
        .SBA_mispredCnt_o      (SBA_mispredCnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        EXE_up_valid_w_i      = 1'b0;
        EXE_up_VAddr_i        = '0;
        EXE_up_writeNum_i     = '0;
        EXE_up_aluRes_i       = '0;
        EXE_up_isBranch_i     = 1'b0;
        EXE_up_branchRisk_i   = 1'b0;
        EXE_up_corrTake_i     = 1'b0;
        EXE_up_corrDest_i     = '0;
        EXE_up_repairAction_i = '0;
        EXE_up_checkPoint_i   = '0;
    endtask

    task automatic send(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] alu,
                        input logic br, input logic risk, input logic take,
                        input logic [31:0] dest, input logic [3:0] ra, input logic [7:0] ck);
        EXE_up_valid_w_i      = 1'b1;
        EXE_up_VAddr_i        = pc;
        EXE_up_writeNum_i     = wn;
        EXE_up_aluRes_i       = alu;
        EXE_up_isBranch_i     = br;
        EXE_up_branchRisk_i   = risk;
        EXE_up_corrTake_i     = take;
        EXE_up_corrDest_i     = dest;
        EXE_up_repairAction_i = ra;
        EXE_up_checkPoint_i   = ck;
    endtask

    initial begin
        logic [31:0] exp_pc [5];
        logic        exp_tk [5];
        logic [31:0] exp_dst[5];
        for (int i = 0; i < 5; i++) begin
            exp_pc[i]  = 32'h0000_0100 + 32'(4 * i);
            exp_tk[i]  = i[0];
            exp_dst[i] = 32'h0000_1000 + 32'(16 * i);
        end

        rst = 1'b0;
        idle();
        NEXT_allowin_w_i = 1'b1;
        CP0_excOccur_w_i = 1'b0;
        BPU_updReady_i   = 1'b0;
        #1;
        check("init_allowin", SBA_allowin_w_o, 0);
        check("init_updvalid", BPU_updValid_o, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("post_rst_allowin", SBA_allowin_w_o, 1);
        check("post_rst_valid", SBA_valid_w_o, 0);

        // Back-to-back non-branch results
        send(32'h0, 5'd3, 32'h11, 0, 0, 0, 32'h0, 4'h0, 8'h0);
        tick();
        send(32'h0, 5'd4, 32'h22, 0, 0, 0, 32'h0, 4'h0, 8'h0);
        #1;
        check("b2b_valid0", SBA_valid_w_o, 1);
        check("b2b_alu0", SBA_aluRes_o, 32'h11);
        check("b2b_wn0", SBA_writeNum_o, 3);
        check("b2b_allowin", SBA_allowin_w_o, 1);
        tick();
        idle();
        #1;
        check("b2b_valid1", SBA_valid_w_o, 1);
        check("b2b_alu1", SBA_aluRes_o, 32'h22);
        check("b2b_wn1", SBA_writeNum_o, 4);
        tick();
        #1;
        check("b2b_drained", SBA_valid_w_o, 0);
        check("b2b_no_push", BPU_updValid_o, 0);

        // Predicted-correct branch
        send(32'h8000_0010, 5'd0, 32'h0, 1, 0, 1, 32'h8000_0040, 4'h0, 8'h0);
        tick();
        idle();
        #1;
        check("ok_br_flush", SBA_flush_w_o, 0);
        check("ok_br_valid", SBA_valid_w_o, 1);
        tick();
        #1;
        check("ok_br_updvalid", BPU_updValid_o, 1);
        check("ok_br_pc", BPU_updPC_o, 32'h8000_0010);
        check("ok_br_take", BPU_updTake_o, 1);
        check("ok_br_dest", BPU_updDest_o, 32'h8000_0040);

        // Mispredict while downstream stalls three cycles
        NEXT_allowin_w_i = 1'b0;
        send(32'h8000_0020, 5'd0, 32'h0, 1, 1, 0, 32'hBFC0_0100, 4'h9, 8'h5A);
        tick();
        idle();
        #1;
        check("mp_flush", SBA_flush_w_o, 1);
        check("mp_redirect", SBA_redirectPC_o, 32'hBFC0_0100);
        check("mp_repair", SBA_repairAction_o, 4'h9);
        check("mp_ckpt", SBA_checkPoint_o, 8'h5A);
        check("mp_allowin_stall", SBA_allowin_w_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("mp_flush_once", SBA_flush_w_o, 0);
            check("mp_cnt", SBA_mispredCnt_o, 1);
        end
        NEXT_allowin_w_i = 1'b1;
        #1;
        check("mp_release_valid", SBA_valid_w_o, 1);
        tick();
        #1;
        check("mp_after_flush", SBA_flush_w_o, 0);
        check("mp_head_kept", BPU_updPC_o, 32'h8000_0010);

        // Reset with an instruction held and two FIFO entries
        NEXT_allowin_w_i = 1'b0;
        send(32'h0, 5'd7, 32'h33, 0, 0, 0, 32'h0, 4'h0, 8'h0);
        tick();
        idle();
        #1;
        check("mr_hasdata", SBA_valid_w_o, 1);
        rst = 1'b0;
        #1;
        check("mr_allowin", SBA_allowin_w_o, 0);
        check("mr_valid", SBA_valid_w_o, 0);
        check("mr_wn", SBA_writeNum_o, 0);
        check("mr_alu", SBA_aluRes_o, 0);
        check("mr_flush", SBA_flush_w_o, 0);
        check("mr_redirect", SBA_redirectPC_o, 0);
        check("mr_repair", SBA_repairAction_o, 0);
        check("mr_ckpt", SBA_checkPoint_o, 0);
        check("mr_updvalid", BPU_updValid_o, 0);
        check("mr_updpc", BPU_updPC_o, 0);
        check("mr_updtake", BPU_updTake_o, 0);
        check("mr_upddest", BPU_updDest_o, 0);
        check("mr_cnt", SBA_mispredCnt_o, 0);
        tick();
        rst = 1'b1;
        NEXT_allowin_w_i = 1'b1;
        #1;
        check("mr_release_allowin", SBA_allowin_w_o, 1);

        // Fill the FIFO and back-pressure a fifth branch
        for (int i = 0; i < 5; i++) begin
            send(exp_pc[i], 5'd0, 32'h0, 1, 0, exp_tk[i], exp_dst[i], 4'h0, 8'h0);
            tick();
        end
        idle();
        #1;
        check("full_valid", SBA_valid_w_o, 0);
        check("full_allowin", SBA_allowin_w_o, 0);
        check("full_head", BPU_updPC_o, exp_pc[0]);
        tick();
        #1;
        check("full_hold_valid", SBA_valid_w_o, 0);
        BPU_updReady_i = 1'b1;
        #1;
        check("popush_valid", SBA_valid_w_o, 1);
        check("popush_allowin", SBA_allowin_w_o, 1);
        tick();
        BPU_updReady_i = 1'b0;
        #1;
        check("popush_head", BPU_updPC_o, exp_pc[1]);
        check("popush_empty_stage", SBA_valid_w_o, 0);

        // Exception and mispredict in the same cycle
        NEXT_allowin_w_i = 1'b0;
        send(32'h0000_0300, 5'd0, 32'h0, 1, 1, 1, 32'h0000_0400, 4'h8, 8'h11);
        tick();
        idle();
        CP0_excOccur_w_i = 1'b1;
        #1;
        check("exc_flush", SBA_flush_w_o, 0);
        check("exc_valid", SBA_valid_w_o, 0);
        tick();
        CP0_excOccur_w_i = 1'b0;
        #1;
        check("exc_flush_after", SBA_flush_w_o, 0);
        check("exc_allowin", SBA_allowin_w_o, 1);
        check("exc_cnt", SBA_mispredCnt_o, 0);
        check("exc_head", BPU_updPC_o, exp_pc[1]);

        // Drain: exactly four entries remain, in order
        NEXT_allowin_w_i = 1'b1;
        BPU_updReady_i   = 1'b1;
        for (int i = 1; i < 5; i++) begin
            #1;
            check("drain_valid", BPU_updValid_o, 1);
            check("drain_pc", BPU_updPC_o, exp_pc[i]);
            check("drain_take", BPU_updTake_o, exp_tk[i]);
            check("drain_dest", BPU_updDest_o, exp_dst[i]);
            tick();
        end
        BPU_updReady_i = 1'b0;
        #1;
        check("drain_empty", BPU_updValid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
